// File: rtl/config_ctrl.sv
// config_ctrl
//   Write-port owner for the router configuration register bank.
//   After reset it writes a boot default into each of the four bank
//   registers. It then arbitrates round-robin between two valid/ready
//   requesters. No write is issued while the datapath reports a packet
//   in flight.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high
//   busy         datapath packet in flight; blocks every write
//   reqN_valid   requester N write request (N = 0, 1)
//   reqN_addr    requester N register address
//   reqN_data    requester N write data
//   reqN_ready   requester N grant; a transfer occurs on valid & ready
//   config_addr  bank write address (registered)
//   config_data  bank write data (registered)
//   config_en    bank write strobe, one cycle per write (registered)
//   init_done    boot sequence complete, sticky until reset
module config_ctrl #(
  parameter logic [1:0] DEF_CH0_ADDR = 2'h0,
  parameter logic [1:0] DEF_CH1_ADDR = 2'h1,
  parameter logic [1:0] DEF_CH2_ADDR = 2'h2,
  parameter logic       DEF_CRC_EN   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       busy,
  input  logic       req0_valid,
  input  logic [1:0] req0_addr,
  input  logic [1:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_addr,
  input  logic [1:0] req1_data,
  output logic       req1_ready,
  output logic [1:0] config_addr,
  output logic [1:0] config_data,
  output logic       config_en,
  output logic       init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t     state_q;
  logic [1:0] init_cnt_q;
  logic       last_grant_q;   // requester granted on the most recent tie
  logic [1:0] config_addr_q;
  logic [1:0] config_data_q;
  logic       config_en_q;
  logic       init_done_q;

  logic       run_ok;
  logic       grant0;
  logic       grant1;
  logic [1:0] boot_data_d;
  logic [1:0] wr_addr_d;
  logic [1:0] wr_data_d;

  // Boot default for the register currently being initialised.
  always_comb begin
    boot_data_d = DEF_CH0_ADDR;
    case (init_cnt_q)
      2'd0:    boot_data_d = DEF_CH0_ADDR;
      2'd1:    boot_data_d = DEF_CH1_ADDR;
      2'd2:    boot_data_d = DEF_CH2_ADDR;
      default: boot_data_d = {1'b0, DEF_CRC_EN};
    endcase
  end

  // Grants are combinational so a requester sees ready in the same cycle
  // that it raises valid. On a tie, the requester that did not win the
  // previous tie is granted.
  assign run_ok = (state_q == ST_RUN) && !busy;
  assign grant0 = run_ok && req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = run_ok && req1_valid && (!req0_valid || !last_grant_q);

  assign wr_addr_d = grant1 ? req1_addr : req0_addr;
  assign wr_data_d = grant1 ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= 2'd0;
      last_grant_q  <= 1'b1;
      config_addr_q <= 2'h0;
      config_data_q <= 2'h0;
      config_en_q   <= 1'b0;
      init_done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (!busy) begin
            config_en_q   <= 1'b1;
            config_addr_q <= init_cnt_q;
            config_data_q <= boot_data_d;
            init_cnt_q    <= init_cnt_q + 2'd1;
            if (init_cnt_q == 2'd3) begin
              state_q     <= ST_RUN;
              init_done_q <= 1'b1;
            end
          end else begin
            config_en_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (grant0 || grant1) begin
            config_en_q   <= 1'b1;
            config_addr_q <= wr_addr_d;
            config_data_q <= wr_data_d;
            // The pointer only moves when there was actual contention.
            if (req0_valid && req1_valid) begin
              last_grant_q <= grant1;
            end
          end else begin
            config_en_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign config_addr = config_addr_q;
  assign config_data = config_data_q;
  assign config_en   = config_en_q;
  assign init_done   = init_done_q;

endmodule
